led_mode_ctrl: RTL and testbench

Controller for the board's 4-LED running-light datapath. Debounces two push keys and selects one of four LED patterns plus one of four step speeds, then sequences the LED register. It replaces the fixed 1 s left-rotate with a user-driven scheduler. It sits between the raw key pins and the LED pins.

---
 rtl/led_ctrl_pkg.sv | 20 ++
 rtl/key_debounce.sv | 60 ++++++
 rtl/led_mode_ctrl.sv | 150 +++++++++++++++
 tb/tb_led_mode_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared encodings for the LED running-light controller: pattern modes,
// speed index width/limit and ping-pong direction.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_LEFT     = 2'd0,
    MODE_RIGHT    = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_BLINK    = 2'd3
  } mode_t;

  localparam int SPEED_W = 2;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 2'd3;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

endpackage

// File: rtl/key_debounce.sv
// Key conditioning: 2-FF synchroniser, stability counter and a one-cycle
// press pulse on an accepted 1->0 (press) transition. Keys are active-low
// and idle high, so every register resets to the released level.
module key_debounce
  import led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_key,
  output logic o_press
);

  localparam int DB_W = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CNT - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_stable;
  logic            r_press;
  logic [DB_W-1:0] r_cnt;

  // Bring the raw pin into the clock domain.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CNT cycles;
  // the press pulse is raised on the same edge the stable level falls.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 != r_stable) begin
        if (r_cnt == DB_LAST) begin
          r_cnt    <= '0;
          r_stable <= r_sync2;
          r_press  <= r_stable & ~r_sync2;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/led_mode_ctrl.sv
// LED running-light controller: two debounced keys select one of four
// patterns and one of four step speeds; a step counter sequences the LEDs.
// Optional build macro LED_PAUSE_KEY_EN adds a third key that toggles a
// pause which freezes both the step counter and the LED register.
module led_mode_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int STEP_CNT_MAX = 50_000_000,
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int LED_W        = 4
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               key_mode,
  input  logic               key_speed,
`ifdef LED_PAUSE_KEY_EN
  input  logic               key_pause,
`endif
  output logic [LED_W-1:0]   led,
  output logic [1:0]         mode,
  output logic [SPEED_W-1:0] speed
);

  localparam int CNT_W = $clog2(STEP_CNT_MAX);
  // STEP_CNT_MAX is a multiple of 8, so (MAX-1) >> s equals (MAX >> s) - 1.
  localparam logic [CNT_W-1:0] CNT_LAST0 = CNT_W'(STEP_CNT_MAX - 1);
  localparam logic [LED_W-1:0] LED_LSB   = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] LED_MSB   = {1'b1, {(LED_W-1){1'b0}}};

  function automatic logic [LED_W-1:0] f_init(input mode_t m);
    case (m)
      MODE_RIGHT: f_init = LED_MSB;
      MODE_BLINK: f_init = '1;
      default:    f_init = LED_LSB;
    endcase
  endfunction

  logic w_mode_press;
  logic w_speed_press;
  logic w_run;
  logic w_tick;
  logic [CNT_W-1:0] w_cnt_last;
  logic [1:0]       w_mode_inc;

  mode_t              r_mode,  w_mode_next;
  dir_t               r_dir,   w_dir_next;
  logic [SPEED_W-1:0] r_speed, w_speed_next;
  logic [LED_W-1:0]   r_led,   w_led_next;
  logic [CNT_W-1:0]   r_cnt,   w_cnt_next;

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_mode (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_key     (key_mode),
    .o_press   (w_mode_press)
  );

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_speed (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_key     (key_speed),
    .o_press   (w_speed_press)
  );

`ifdef LED_PAUSE_KEY_EN
  logic w_pause_press;
  logic r_paused;

  key_debounce #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_key_pause (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i_key     (key_pause),
    .o_press   (w_pause_press)
  );

  // Each accepted pause press flips the pause flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_paused <= 1'b0;
    else if (w_pause_press) r_paused <= ~r_paused;
  end

  assign w_run = ~r_paused;
`else
  assign w_run = 1'b1;
`endif

  assign w_cnt_last = CNT_LAST0 >> r_speed;
  assign w_tick     = w_run && (r_cnt == w_cnt_last);
  assign w_mode_inc = r_mode + 2'd1;

  // State register for mode, speed, direction, LEDs and step counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_mode  <= MODE_LEFT;
      r_speed <= '0;
      r_dir   <= DIR_LEFT;
      r_led   <= LED_LSB;
      r_cnt   <= '0;
    end else begin
      r_mode  <= w_mode_next;
      r_speed <= w_speed_next;
      r_dir   <= w_dir_next;
      r_led   <= w_led_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next state: a key press overrides any step tick in the same cycle.
  always_comb begin
    w_mode_next  = r_mode;
    w_speed_next = r_speed;
    w_dir_next   = r_dir;
    w_led_next   = r_led;
    w_cnt_next   = r_cnt;
    if (w_mode_press || w_speed_press) begin
      w_cnt_next = '0;
      if (w_speed_press) begin
        w_speed_next = (r_speed == SPEED_MAX) ? '0 : r_speed + 1'b1;
      end
      if (w_mode_press) begin
        w_mode_next = mode_t'(w_mode_inc);
        w_led_next  = f_init(mode_t'(w_mode_inc));
        w_dir_next  = DIR_LEFT;
      end
    end else if (w_tick) begin
      w_cnt_next = '0;
      case (r_mode)
        MODE_LEFT:  w_led_next = {r_led[LED_W-2:0], r_led[LED_W-1]};
        MODE_RIGHT: w_led_next = {r_led[0], r_led[LED_W-1:1]};
        MODE_PINGPONG: begin
          if (r_dir == DIR_LEFT) begin
            w_led_next = r_led << 1;
            if (w_led_next[LED_W-1]) w_dir_next = DIR_RIGHT;
          end else begin
            w_led_next = r_led >> 1;
            if (w_led_next[0]) w_dir_next = DIR_LEFT;
          end
        end
        default:    w_led_next = ~r_led;
      endcase
    end else if (w_run) begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  assign led   = r_led;
  assign mode  = r_mode;
  assign speed = r_speed;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with STEP_CNT_MAX=16, DEBOUNCE_CNT=4.
// A key press driven right after an edge is consumed on the 7th edge; the
// press task then releases and waits out the release debounce (13 edges).
module tb_led_mode_ctrl;

  localparam int OP_RUN = 0;
  localparam int OP_PM  = 1;
  localparam int OP_PS  = 2;
  localparam int OP_PB  = 3;
  localparam int OP_RST = 4;

  typedef struct {
    int         op;
    int         n;
    logic [3:0] led;
    logic [1:0] mode;
    logic [1:0] speed;
  } vec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_mode = 1'b1;
  logic       key_speed = 1'b1;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
`ifdef LED_PAUSE_KEY_EN
  logic       key_pause = 1'b1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[64];
  int nv = 0;

  always #5 sys_clk = ~sys_clk;

  led_mode_ctrl #(.STEP_CNT_MAX(16), .DEBOUNCE_CNT(4), .LED_W(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_mode  (key_mode),
    .key_speed (key_speed),
`ifdef LED_PAUSE_KEY_EN
    .key_pause (key_pause),
`endif
    .led       (led),
    .mode      (mode),
    .speed     (speed)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic reset_dut();
    sys_rst_n = 1'b0;
    #2;
    sys_rst_n = 1'b1;
  endtask

  task automatic press(input logic pm, input logic ps);
    if (pm) key_mode = 1'b0;
    if (ps) key_speed = 1'b0;
    repeat (7) tick();
    key_mode  = 1'b1;
    key_speed = 1'b1;
    repeat (6) tick();
  endtask

  task automatic push(input int op, input int n, input logic [3:0] l,
                      input logic [1:0] m, input logic [1:0] s);
    vecs[nv] = '{op, n, l, m, s};
    nv++;
  endtask

  initial begin
    int   changes;
    int   change_edge;
    logic [1:0] prev_mode;
    logic [3:0] prev_led;

    // Basic left rotation and wrap.
    push(OP_RST, 0,  4'b0001, 2'd0, 2'd0);
    push(OP_RUN, 15, 4'b0001, 2'd0, 2'd0);
    push(OP_RUN, 1,  4'b0010, 2'd0, 2'd0);
    push(OP_RUN, 47, 4'b1000, 2'd0, 2'd0);
    push(OP_RUN, 1,  4'b0001, 2'd0, 2'd0);
    // Speed stepping: period 8, then back to 16 after four presses.
    push(OP_RST, 0,  4'b0001, 2'd0, 2'd0);
    push(OP_PS,  0,  4'b0001, 2'd0, 2'd1);
    push(OP_RUN, 1,  4'b0001, 2'd0, 2'd1);
    push(OP_RUN, 1,  4'b0010, 2'd0, 2'd1);
    push(OP_RUN, 7,  4'b0010, 2'd0, 2'd1);
    push(OP_RUN, 1,  4'b0100, 2'd0, 2'd1);
    push(OP_PS,  0,  4'b1000, 2'd0, 2'd2);
    push(OP_PS,  0,  4'b0001, 2'd0, 2'd3);
    push(OP_PS,  0,  4'b1000, 2'd0, 2'd0);
    push(OP_RUN, 9,  4'b1000, 2'd0, 2'd0);
    push(OP_RUN, 1,  4'b0001, 2'd0, 2'd0);
    // Ping-pong sequence.
    push(OP_RST, 0,  4'b0001, 2'd0, 2'd0);
    push(OP_PM,  0,  4'b1000, 2'd1, 2'd0);
    push(OP_PM,  0,  4'b0001, 2'd2, 2'd0);
    push(OP_RUN, 9,  4'b0001, 2'd2, 2'd0);
    push(OP_RUN, 1,  4'b0010, 2'd2, 2'd0);
    push(OP_RUN, 16, 4'b0100, 2'd2, 2'd0);
    push(OP_RUN, 16, 4'b1000, 2'd2, 2'd0);
    push(OP_RUN, 16, 4'b0100, 2'd2, 2'd0);
    push(OP_RUN, 16, 4'b0010, 2'd2, 2'd0);
    push(OP_RUN, 16, 4'b0001, 2'd2, 2'd0);
    push(OP_RUN, 16, 4'b0010, 2'd2, 2'd0);
    // Blink, wrap of mode to 0, right rotation.
    push(OP_PM,  0,  4'b1111, 2'd3, 2'd0);
    push(OP_RUN, 9,  4'b1111, 2'd3, 2'd0);
    push(OP_RUN, 1,  4'b0000, 2'd3, 2'd0);
    push(OP_RUN, 16, 4'b1111, 2'd3, 2'd0);
    push(OP_PM,  0,  4'b0001, 2'd0, 2'd0);
    push(OP_PM,  0,  4'b1000, 2'd1, 2'd0);
    push(OP_RUN, 9,  4'b1000, 2'd1, 2'd0);
    push(OP_RUN, 1,  4'b0100, 2'd1, 2'd0);
    push(OP_RUN, 16, 4'b0010, 2'd1, 2'd0);
    push(OP_RUN, 16, 4'b0001, 2'd1, 2'd0);
    push(OP_RUN, 16, 4'b1000, 2'd1, 2'd0);
    // Mode and speed pressed together.
    push(OP_PB,  0,  4'b0001, 2'd2, 2'd1);
    push(OP_RUN, 1,  4'b0001, 2'd2, 2'd1);
    push(OP_RUN, 1,  4'b0010, 2'd2, 2'd1);

    // Reset state while reset is held.
    #12;
    check("reset_led", 32'(led), 32'h1);
    check("reset_mode", 32'(mode), 32'h0);
    check("reset_speed", 32'(speed), 32'h0);
    tick();

    for (int i = 0; i < nv; i++) begin
      case (vecs[i].op)
        OP_RUN:  repeat (vecs[i].n) tick();
        OP_PM:   press(1'b1, 1'b0);
        OP_PS:   press(1'b0, 1'b1);
        OP_PB:   press(1'b1, 1'b1);
        default: reset_dut();
      endcase
      check($sformatf("vec%0d_led", i), 32'(led), 32'(vecs[i].led));
      check($sformatf("vec%0d_mode", i), 32'(mode), 32'(vecs[i].mode));
      check($sformatf("vec%0d_speed", i), 32'(speed), 32'(vecs[i].speed));
      $display("vec %0d op=%0d n=%0d led=%b mode=%0d speed=%0d", i, vecs[i].op,
               vecs[i].n, led, mode, speed);
    end

    // Glitchy mode key: exactly one accepted press, none on release.
    reset_dut();
    changes = 0;
    change_edge = 0;
    prev_mode = 2'd0;
    for (int e = 1; e <= 30; e++) begin
      key_mode = (e == 3 || e >= 16) ? 1'b1 : 1'b0;
      tick();
      if (mode != prev_mode) begin
        changes++;
        change_edge = e;
      end
      prev_mode = mode;
      if (e == 10) check("glitch_led_on_pulse", 32'(led), 32'h8);
    end
    check("glitch_press_count", 32'(changes), 32'd1);
    check("glitch_press_edge", 32'(change_edge), 32'd10);
    check("glitch_mode", 32'(mode), 32'd1);
    check("glitch_led_end", 32'(led), 32'h4);
    $display("glitch seq: presses=%0d edge=%0d mode=%0d led=%b", changes, change_edge, mode, led);

    // Mode press landing on the step tick: press wins, counter restarts.
    reset_dut();
    repeat (9) tick();
    key_mode = 1'b0;
    change_edge = 0;
    prev_led = 4'b1000;
    for (int e = 1; e <= 23; e++) begin
      tick();
      if (e == 7) begin
        check("tickpress_led", 32'(led), 32'h8);
        check("tickpress_mode", 32'(mode), 32'd1);
        key_mode = 1'b1;
      end else if (e > 7 && change_edge == 0 && led != prev_led) begin
        change_edge = e;
      end
    end
    check("tickpress_next_edge", 32'(change_edge), 32'd23);
    check("tickpress_next_led", 32'(led), 32'h4);
    $display("tick-press seq: next change edge=%0d led=%b", change_edge, led);

    // Asynchronous reset in mode 3, speed 2.
    reset_dut();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    check("pre_rst_mode", 32'(mode), 32'd3);
    check("pre_rst_speed", 32'(speed), 32'd2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async_rst_led", 32'(led), 32'h1);
    check("async_rst_mode", 32'(mode), 32'd0);
    check("async_rst_speed", 32'(speed), 32'd0);
    $display("async reset seq: led=%b mode=%0d speed=%0d", led, mode, speed);
    #3;
    sys_rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
